reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 177 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for an out-of-order core.
// Entries are addressed by tag 1..2^ENTRY_SIZE-1; tag 0 is the null tag.
// Results arrive out of order on the CDB. The head entry retires once it is
// ready. A mispredicted branch at retirement flushes the whole buffer.
// Optional macro ROB_FAST_COMMIT_EN: a CDB write that hits the busy head
// entry retires it on the same edge. This saves one cycle of latency.
module reorder_buffer #(
  parameter int ENTRY_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  input  logic [5:0]            issue_rd,
  input  logic                  issue_is_branch,
  input  logic                  issue_pred_taken,
  output logic [ENTRY_SIZE-1:0] rob_new_entry,
  output logic                  rob_full,
  input  logic                  cdb_valid,
  input  logic [ENTRY_SIZE-1:0] cdb_entry,
  input  logic [31:0]           cdb_result,
  input  logic                  cdb_taken,
  input  logic [31:0]           cdb_next_pc,
  output logic                  rob_commit,
  output logic [ENTRY_SIZE-1:0] rob_entry,
  output logic [5:0]            rob_des,
  output logic [31:0]           rob_result,
  output logic                  roll_back,
  output logic [31:0]           roll_back_pc
);

  localparam int DEPTH = 1 << ENTRY_SIZE;
  // The last valid tag equals the capacity, because tag 0 is never used.
  localparam logic [ENTRY_SIZE-1:0] LAST_TAG = '1;
  localparam logic [ENTRY_SIZE-1:0] TAG_ONE  = ENTRY_SIZE'(1);

  // Per-entry control state, cleared by reset and by flush.
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      r_ready;
  // Per-entry payload. It is only meaningful while the entry is busy.
  logic [DEPTH-1:0]      r_is_branch;
  logic [DEPTH-1:0]      r_pred_taken;
  logic [DEPTH-1:0]      r_taken;
  logic [5:0]            r_rd      [DEPTH];
  logic [31:0]           r_result  [DEPTH];
  logic [31:0]           r_next_pc [DEPTH];

  logic [ENTRY_SIZE-1:0] r_head;
  logic [ENTRY_SIZE-1:0] r_tail;
  logic [ENTRY_SIZE-1:0] r_count;

  logic                  r_commit;
  logic [ENTRY_SIZE-1:0] r_entry;
  logic [5:0]            r_des;
  logic [31:0]           r_result_out;
  logic                  r_roll_back;
  logic [31:0]           r_roll_back_pc;

  logic                  w_full;
  logic                  w_cdb_hit;
  logic                  w_head_done;
  logic                  w_head_taken;
  logic [31:0]           w_head_result;
  logic [31:0]           w_head_next_pc;
  logic                  w_retire;
  logic                  w_flush;
  logic                  w_issue;
  logic                  w_cdb_wr;

  // Pointer increment that skips the null tag.
  function automatic logic [ENTRY_SIZE-1:0] next_tag(input logic [ENTRY_SIZE-1:0] t);
    return (t == LAST_TAG) ? TAG_ONE : t + TAG_ONE;
  endfunction

  // Decide what happens at this edge: retire, flush, issue and CDB write.
  always_comb begin
    w_full         = (r_count == LAST_TAG);
    w_cdb_hit      = cdb_valid && (cdb_entry != '0) && r_busy[cdb_entry];
    w_head_done    = r_ready[r_head];
    w_head_taken   = r_taken[r_head];
    w_head_result  = r_result[r_head];
    w_head_next_pc = r_next_pc[r_head];
`ifdef ROB_FAST_COMMIT_EN
    if (w_cdb_hit && (cdb_entry == r_head)) begin
      w_head_done    = 1'b1;
      w_head_taken   = cdb_taken;
      w_head_result  = cdb_result;
      w_head_next_pc = cdb_next_pc;
    end
`endif
    w_retire = rdy_in && r_busy[r_head] && w_head_done;
    w_flush  = w_retire && r_is_branch[r_head] && (w_head_taken != r_pred_taken[r_head]);
    // A flush discards any issue or CDB write sampled on the same edge.
    w_issue  = rdy_in && issue_valid && !w_full && !w_flush;
    w_cdb_wr = rdy_in && w_cdb_hit && !w_flush;
  end

  // Control state: pointers, occupancy, entry flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_busy         <= '0;
      r_ready        <= '0;
      r_head         <= TAG_ONE;
      r_tail         <= TAG_ONE;
      r_count        <= '0;
      r_commit       <= 1'b0;
      r_entry        <= '0;
      r_des          <= '0;
      r_result_out   <= '0;
      r_roll_back    <= 1'b0;
      r_roll_back_pc <= '0;
    end else if (!rdy_in) begin
      r_commit    <= 1'b0;
      r_roll_back <= 1'b0;
    end else begin
      r_commit    <= w_retire;
      r_roll_back <= w_flush;
      if (w_retire) begin
        r_entry      <= r_head;
        r_des        <= r_is_branch[r_head] ? 6'd0 : r_rd[r_head];
        r_result_out <= w_head_result;
      end
      if (w_flush) begin
        r_roll_back_pc <= w_head_next_pc;
        r_busy         <= '0;
        r_ready        <= '0;
        r_head         <= TAG_ONE;
        r_tail         <= TAG_ONE;
        r_count        <= '0;
      end else begin
        if (w_cdb_wr) begin
          r_ready[cdb_entry] <= 1'b1;
        end
        if (w_retire) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= next_tag(r_head);
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= next_tag(r_tail);
        end
        case ({w_issue, w_retire})
          2'b10:   r_count <= r_count + TAG_ONE;
          2'b01:   r_count <= r_count - TAG_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload capture. The busy/ready flags gate its use, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_rd[r_tail]         <= issue_rd;
      r_is_branch[r_tail]  <= issue_is_branch;
      r_pred_taken[r_tail] <= issue_pred_taken;
    end
    if (w_cdb_wr) begin
      r_result[cdb_entry]  <= cdb_result;
      r_taken[cdb_entry]   <= cdb_taken;
      r_next_pc[cdb_entry] <= cdb_next_pc;
    end
  end

  assign rob_new_entry = r_tail;
  assign rob_full      = w_full;
  // Pulses are forced low while the block is frozen.
  assign rob_commit    = r_commit & rdy_in;
  assign roll_back     = r_roll_back & rdy_in;
  assign rob_entry     = r_entry;
  assign rob_des       = r_des;
  assign rob_result    = r_result_out;
  assign roll_back_pc  = r_roll_back_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a scoreboard. It pushes expected
// commits and state snapshots into queues. A negedge monitor pops them and compares.
module tb_reorder_buffer;
  localparam int ES = 4;
`ifdef ROB_FAST_COMMIT_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_in;
  logic          rdy_in;
  logic          issue_valid;
  logic [5:0]    issue_rd;
  logic          issue_is_branch;
  logic          issue_pred_taken;
  logic [ES-1:0] rob_new_entry;
  logic          rob_full;
  logic          cdb_valid;
  logic [ES-1:0] cdb_entry;
  logic [31:0]   cdb_result;
  logic          cdb_taken;
  logic [31:0]   cdb_next_pc;
  logic          rob_commit;
  logic [ES-1:0] rob_entry;
  logic [5:0]    rob_des;
  logic [31:0]   rob_result;
  logic          roll_back;
  logic [31:0]   roll_back_pc;

  reorder_buffer #(.ENTRY_SIZE(ES)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
    .rob_new_entry(rob_new_entry), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_result(cdb_result),
    .cdb_taken(cdb_taken), .cdb_next_pc(cdb_next_pc),
    .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des),
    .rob_result(rob_result), .roll_back(roll_back), .roll_back_pc(roll_back_pc)
  );

  typedef struct {
    int          entry;
    int          des;
    logic [31:0] res;
    bit          rb;
    logic [31:0] rbpc;
    int          cyc;
  } exp_t;

  typedef struct {
    bit    full;
    int    nentry;
    bit    zero;
    bit    nocommit;
    bit    drain;
    string name;
  } st_t;

  exp_t exp_q[$];
  st_t  st_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare commits against the scoreboard, then pending state snapshots.
  always @(negedge clk) begin : monitor
    exp_t e;
    st_t  s;
    if (rob_commit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: got entry %0d des %0d, expected no commit (cycle %0d)",
                 rob_entry, rob_des, cyc);
      end else begin
        e = exp_q.pop_front();
        check("commit_entry", rob_entry, e.entry);
        check("commit_des", rob_des, e.des);
        check("commit_result", rob_result, e.res);
        check("commit_roll_back", roll_back, e.rb);
        if (e.rb) check("roll_back_pc", roll_back_pc, e.rbpc);
        if (e.cyc >= 0) check("commit_cycle", cyc, e.cyc);
      end
    end else if (roll_back) begin
      n_checks++;
      n_fail++;
      $display("FAIL roll_back_alone: got roll_back=1, expected 0 without commit (cycle %0d)", cyc);
    end
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      check({s.name, "_full"}, rob_full, s.full);
      check({s.name, "_new_entry"}, rob_new_entry, s.nentry);
      if (s.zero) begin
        check({s.name, "_commit"}, rob_commit, 0);
        check({s.name, "_roll_back"}, roll_back, 0);
        check({s.name, "_entry"}, rob_entry, 0);
        check({s.name, "_des"}, rob_des, 0);
        check({s.name, "_result"}, rob_result, 0);
        check({s.name, "_rbpc"}, roll_back_pc, 0);
      end
      if (s.nocommit) check({s.name, "_stall_commit"}, rob_commit, 0);
      if (s.drain) check({s.name, "_pending"}, exp_q.size(), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_st(input bit full, input int nentry, input bit zero,
                         input bit nocommit, input bit drain, input string name);
    st_t s;
    s.full = full; s.nentry = nentry; s.zero = zero;
    s.nocommit = nocommit; s.drain = drain; s.name = name;
    st_q.push_back(s);
  endtask

  task automatic push_exp(input int entry, input int des, input logic [31:0] res,
                          input bit rb, input logic [31:0] rbpc, input int c);
    exp_t e;
    e.entry = entry; e.des = des; e.res = res; e.rb = rb; e.rbpc = rbpc; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
  endtask

  task automatic issue(input int rd, input bit br, input bit pt);
    issue_valid = 1'b1;
    issue_rd = 6'(rd);
    issue_is_branch = br;
    issue_pred_taken = pt;
    step();
    issue_valid = 1'b0;
    issue_is_branch = 1'b0;
    issue_pred_taken = 1'b0;
  endtask

  task automatic cdb_drive(input int tag, input logic [31:0] res, input bit tk,
                           input logic [31:0] npc, output int e);
    cdb_valid = 1'b1;
    cdb_entry = ES'(tag);
    cdb_result = res;
    cdb_taken = tk;
    cdb_next_pc = npc;
    e = cyc + 1;
    step();
    cdb_valid = 1'b0;
  endtask

  // Completing the current head: the commit is expected LAT edges after the CDB edge.
  task automatic cdb_exp(input int tag, input logic [31:0] res, input bit tk,
                         input logic [31:0] npc, input int des, input bit rb);
    int e;
    cdb_drive(tag, res, tk, npc, e);
    push_exp(tag, des, res, rb, npc, e + LAT);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e1;
    int e3;
    rst_in = 1'b0; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
    cdb_valid = 1'b0; cdb_entry = '0; cdb_result = '0; cdb_taken = 1'b0; cdb_next_pc = '0;

    // Reset state.
    idle(2);
    push_st(0, 1, 1, 0, 0, "reset");
    rst_in = 1'b1;

    // Single issue and completion.
    issue(5, 0, 0);
    push_st(0, 2, 0, 0, 0, "after_issue");
    cdb_exp(1, 32'h1234, 0, 0, 5, 0);
    idle(4);
    push_st(0, 2, 0, 0, 1, "basic");

    // Fill to capacity, then issue while full, including during a commit.
    do_reset();
    for (int i = 1; i <= 15; i++) issue(i, 0, 0);
    push_st(1, 1, 0, 0, 0, "full");
    issue(20, 0, 0);
    push_st(1, 1, 0, 0, 0, "full_ignored");
    cdb_valid = 1'b1; cdb_entry = ES'(1); cdb_result = 32'h55;
    cdb_taken = 1'b0; cdb_next_pc = '0;
    if (LAT == 0) begin issue_valid = 1'b1; issue_rd = 6'd21; end
    e1 = cyc + 1;
    step();
    cdb_valid = 1'b0;
    issue_valid = 1'b0;
    push_exp(1, 1, 32'h55, 0, 0, e1 + LAT);
    if (LAT == 1) begin
      issue_valid = 1'b1; issue_rd = 6'd21;
      step();
      issue_valid = 1'b0;
    end
    push_st(0, 1, 0, 0, 0, "wrap_after_retire");
    issue(22, 0, 0);
    push_st(1, 2, 0, 0, 0, "refill");
    idle(3);
    push_st(1, 2, 0, 0, 1, "capacity");

    // Out-of-order completion 3, 2, 1 retires in order 1, 2, 3.
    do_reset();
    issue(11, 0, 0); issue(12, 0, 0); issue(13, 0, 0);
    cdb_drive(3, 32'hA3, 0, 0, e1);
    cdb_drive(2, 32'hA2, 0, 0, e1);
    cdb_drive(1, 32'hA1, 0, 0, e3);
    push_exp(1, 11, 32'hA1, 0, 0, e3 + LAT);
    push_exp(2, 12, 32'hA2, 0, 0, e3 + LAT + 1);
    push_exp(3, 13, 32'hA3, 0, 0, e3 + LAT + 2);
    idle(5);
    push_st(0, 4, 0, 0, 1, "ooo");

    // Mispredicted branch flushes younger entries.
    do_reset();
    issue(0, 1, 0);
    issue(7, 0, 0); issue(8, 0, 0); issue(9, 0, 0);
    cdb_drive(2, 32'hB2, 0, 0, e1);
    cdb_exp(1, 32'h0, 1, 32'h100, 0, 1);
    idle(2);
    push_st(0, 1, 0, 0, 0, "after_flush");
    cdb_drive(2, 32'hDEAD, 0, 0, e1);
    issue(3, 0, 0); issue(4, 0, 0); issue(0, 1, 1);
    cdb_exp(1, 32'h77, 0, 0, 3, 0);
    cdb_exp(2, 32'h88, 0, 0, 4, 0);
    cdb_exp(3, 32'h0, 1, 32'h200, 0, 0);
    idle(5);
    push_st(0, 4, 0, 0, 1, "branch");

    // Stall with the head ready.
    do_reset();
    issue(6, 0, 0); issue(7, 0, 0);
    cdb_drive(2, 32'h67, 0, 0, e3);
    cdb_drive(1, 32'h66, 0, 0, e1);
    push_exp(1, 6, 32'h66, 0, 0, (LAT == 0) ? e1 : e1 + 4);
    push_exp(2, 7, 32'h67, 0, 0, e1 + 4 + LAT);
    @(negedge clk);
    #1;
    rdy_in = 1'b0;
    repeat (3) begin
      step();
      push_st(0, 3, 0, 1, 0, "stall");
    end
    rdy_in = 1'b1;
    idle(5);
    push_st(0, 3, 0, 0, 1, "after_stall");

    // Reset with entries in flight.
    do_reset();
    for (int i = 1; i <= 6; i++) issue(i, 0, 0);
    cdb_exp(1, 32'h99, 0, 0, 1, 0);
    idle(3);
    rst_in = 1'b0;
    step();
    push_st(0, 1, 1, 0, 0, "midrun_reset");
    rst_in = 1'b1;
    cdb_drive(2, 32'h22, 0, 0, e1);
    idle(5);
    push_st(0, 1, 0, 0, 1, "post_reset");

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
